// File: rtl/display_controller.sv
// Four-digit 7-segment scan controller: divides the clock into digit slots,
// blanks the anodes at the start of each slot and swaps display words only at frame boundaries.
module display_controller #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] din,
    output logic [1:0]  seg_sel,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] div_cnt;
    logic [15:0]      shadow;
    logic             pending;
    logic             slot_end;
    logic             wrap;

    assign slot_end   = (div_cnt == LAST_CNT);
    assign wrap       = slot_end && (seg_sel == 2'd3);
    assign frame_done = wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            seg_sel <= 2'd0;
        end else if (slot_end) begin
            div_cnt <= '0;
            seg_sel <= seg_sel + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // A load on the wrap cycle goes straight to the display and supersedes any shadowed word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= 16'h0000;
            pending <= 1'b0;
            d0      <= 4'h0;
            d1      <= 4'h0;
            d2      <= 4'h0;
            d3      <= 4'h0;
        end else if (load) begin
            if (wrap) begin
                {d3, d2, d1, d0} <= din;
                pending          <= 1'b0;
            end else begin
                shadow  <= din;
                pending <= 1'b1;
            end
        end else if (wrap && pending) begin
            {d3, d2, d1, d0} <= shadow;
            pending          <= 1'b0;
        end
    end

    always_comb begin
        an = 4'b1111;
        if (div_cnt >= BLANK_CNT) begin
            an = ~(4'b0001 << seg_sel);
        end
    end

endmodule
